// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command-frame controller:
//   state_e        - controller state encoding
//   Err*           - err_code values reported with frame_err
//   HeaderDefault  - default frame start byte
//   frame_csum()   - frame checksum, (header + addr + data) mod 256
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StData  = 3'd2,
        StCsum  = 3'd3,
        StWrite = 3'd4
    } state_e;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrBadAddr = 2'b01;
    localparam logic [1:0] ErrCsum    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    localparam logic [7:0] HeaderDefault = 8'hA5;

    function automatic logic [7:0] frame_csum(input logic [7:0] header,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        frame_csum = header + addr + data;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses command frames HEADER, ADDR, DATA[, CSUM] arriving one byte per
// rx_done strobe from a UART receiver and turns each good frame into a
// single-cycle register write.
//
// Build option: define UART_CMD_CHECKSUM_EN to require and check the CSUM
// byte. Without it frames are three bytes and err_code 10 never occurs.
//
// Parameters:
//   CLOCK_FREQ     - clk_in frequency in Hz
//   TIMEOUT_CYCLES - allowed inter-byte gap in clk_in cycles
//   HEADER         - frame start byte
// Ports:
//   clk_in      in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   received byte, valid with rx_done
//   rx_done     in   one-cycle byte strobe
//   reg_wr_en   out  one-cycle register write strobe
//   reg_wr_addr out  write address, held until the next write
//   reg_wr_data out  write data, held until the next write
//   frame_err   out  one-cycle error strobe
//   err_code    out  01 bad addr, 10 checksum, 11 timeout; held until next error
//   busy        out  high whenever a frame is in progress
// ----------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 32'd50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd50_000,
    parameter logic [7:0]  HEADER         = HeaderDefault
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       reg_wr_en,
    output logic [3:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // A zero TIMEOUT_CYCLES falls back to 1 ms worth of clk_in cycles.
    localparam int unsigned TimeoutMs  = (CLOCK_FREQ / 1000 == 0) ? 1 : CLOCK_FREQ / 1000;
    localparam int unsigned TimeoutEff = (TIMEOUT_CYCLES == 0) ? TimeoutMs : TIMEOUT_CYCLES;
    localparam logic [31:0] GapLimit   = 32'(TimeoutEff - 1);

    state_e      state_q, state_d;
    logic [31:0] gap_q, gap_d;
    // Only the low nibble is stored: an accepted address always has a zero
    // upper nibble, so the full byte is recoverable for the checksum.
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ferr_q, ferr_d;
    logic [1:0]  err_code_q, err_code_d;

    logic in_frame;
    logic timeout;

    // WRITE is excluded so a write and a timeout error can never coincide.
    assign in_frame = (state_q == StAddr) || (state_q == StData) || (state_q == StCsum);
    // A byte arriving on the limit cycle wins over the timeout.
    assign timeout  = in_frame && (gap_q == GapLimit) && !rx_done;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ferr_d     = 1'b0;
        err_code_d = err_code_q;

        if (rx_done || (state_q == StIdle)) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_done && (rx_data == HEADER)) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (rx_done) begin
                    if (rx_data[7:4] != 4'h0) begin
                        ferr_d     = 1'b1;
                        err_code_d = ErrBadAddr;
                        state_d    = StIdle;
                    end else begin
                        addr_d  = rx_data[3:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_done) begin
                    data_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StWrite;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            StCsum: begin
                if (rx_done) begin
                    if (rx_data == frame_csum(HEADER, {4'h0, addr_q}, data_q)) begin
                        state_d = StWrite;
                    end else begin
                        ferr_d     = 1'b1;
                        err_code_d = ErrCsum;
                        state_d    = StIdle;
                    end
                end
            end
`endif
            StWrite: begin
                // Any byte arriving here is dropped, never taken as a header.
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = data_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (timeout) begin
            ferr_d     = 1'b1;
            err_code_d = ErrTimeout;
            state_d    = StIdle;
            gap_d      = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ferr_q     <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ferr_q     <= ferr_d;
            err_code_q <= err_code_d;
        end
    end

    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign frame_err   = ferr_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Self-checking bench for uart_cmd_ctrl. Each scenario places bytes on a
// per-cycle schedule; a stream-level frame parser predicts, per cycle, the
// busy/strobe/held-output word which is compared against the DUT.
// Follows the UART_CMD_CHECKSUM_EN build option of the RTL.
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    localparam int unsigned T      = 16;
    localparam logic [7:0]  HDR    = 8'hA5;
    localparam int          MaxCyc = 640;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk_in = ~clk_in;

    uart_cmd_ctrl #(
        .CLOCK_FREQ     (32'd50_000_000),
        .TIMEOUT_CYCLES (T),
        .HEADER         (HDR)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    int checks = 0;
    int passes = 0;

    // Byte schedule, one optional byte per cycle.
    logic       sch_v [MaxCyc];
    logic [7:0] sch_b [MaxCyc];
    int         sch_ptr;

    // Per-cycle words {busy, wr_en, ferr, err_code, wr_addr, wr_data}.
    logic [16:0] obs_w [MaxCyc];
    logic [16:0] exp_w [MaxCyc];

    // Expected events per cycle and the model's view of held outputs.
    bit         e_busy [MaxCyc];
    bit         e_wr   [MaxCyc];
    bit         e_err  [MaxCyc];
    logic [1:0] e_code [MaxCyc];
    logic [3:0] e_wa   [MaxCyc];
    logic [7:0] e_wd   [MaxCyc];
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_code = 2'b00;

    task automatic sch_clear();
        for (int k = 0; k < MaxCyc; k++) begin
            sch_v[k] = 1'b0;
            sch_b[k] = 8'h00;
        end
        sch_ptr = 0;
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap);
        sch_ptr        = sch_ptr + gap;
        sch_v[sch_ptr] = 1'b1;
        sch_b[sch_ptr] = b;
        sch_ptr++;
    endtask

    task automatic put_frame(input logic [7:0] a, input logic [7:0] d, input int gap,
                             input bit csum_ok);
        logic [7:0] cs;
        cs = HDR + a + d;
        put_byte(HDR, gap);
        put_byte(a, 0);
        put_byte(d, 0);
        if (CsumEn) put_byte(csum_ok ? cs : cs + 8'd1, 0);
    endtask

    task automatic mark_busy(input int from, input int to);
        for (int k = from; k <= to; k++) e_busy[k] = 1'b1;
    endtask

    // Stream-level frame parser predicting outputs for cycles 0..n-1.
    task automatic model_run(input int n);
        int pos;
        int last;
        int hdr;
        int drop;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] b;
        pos = 0; last = 0; hdr = 0; drop = -1; a = 0; d = 0;
        for (int k = 0; k < MaxCyc; k++) begin
            e_busy[k] = 0; e_wr[k] = 0; e_err[k] = 0; e_code[k] = 0; e_wa[k] = 0; e_wd[k] = 0;
        end
        for (int c = 0; c < n; c++) begin
            if (pos != 0 && c == last + int'(T) && !sch_v[c]) begin
                mark_busy(hdr + 1, c);
                e_err[c+1] = 1; e_code[c+1] = 2'b11; pos = 0;
            end else if (sch_v[c] && c != drop) begin
                b = sch_b[c];
                last = c;
                if (pos == 0) begin
                    if (b == HDR) begin pos = 1; hdr = c; end
                end else if (pos == 1) begin
                    if (b[7:4] != 4'h0) begin
                        mark_busy(hdr + 1, c);
                        e_err[c+1] = 1; e_code[c+1] = 2'b01; pos = 0;
                    end else begin
                        a = b; pos = 2;
                    end
                end else if (pos == 2) begin
                    d = b;
                    pos = CsumEn ? 3 : 4;
                end else begin
                    if (b == 8'(HDR + a + d)) begin
                        pos = 4;
                    end else begin
                        mark_busy(hdr + 1, c);
                        e_err[c+1] = 1; e_code[c+1] = 2'b10; pos = 0;
                    end
                end
                if (pos == 4) begin
                    // Final byte: write two cycles later, next cycle's byte is lost.
                    mark_busy(hdr + 1, c + 1);
                    e_wr[c+2] = 1; e_wa[c+2] = a[3:0]; e_wd[c+2] = d;
                    drop = c + 1; pos = 0;
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            if (e_wr[k]) begin m_addr = e_wa[k]; m_data = e_wd[k]; end
            if (e_err[k]) m_code = e_code[k];
            exp_w[k] = {e_busy[k], e_wr[k], e_err[k], m_code, m_addr, m_data};
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic drive(input int n);
        for (int k = 0; k < n; k++) begin
            rx_done = sch_v[k];
            rx_data = sch_v[k] ? sch_b[k] : 8'($urandom);
            @(negedge clk_in);
            obs_w[k] = {busy, reg_wr_en, frame_err, err_code, reg_wr_addr, reg_wr_data};
            @(posedge clk_in);
            #1;
        end
        rx_done = 1'b0;
    endtask

    task automatic run_sched(output int n);
        n = sch_ptr + int'(T) + 4;
        model_run(n);
        drive(n);
    endtask

    function automatic int first_diff(input int n);
        for (int k = 0; k < n; k++) if (obs_w[k] !== exp_w[k]) return k;
        return -1;
    endfunction

    function automatic int count_bit(input int n, input int bitpos);
        int c = 0;
        for (int k = 0; k < n; k++) if (obs_w[k][bitpos]) c++;
        return c;
    endfunction

    function automatic int first_bit(input int n, input int bitpos);
        for (int k = 0; k < n; k++) if (obs_w[k][bitpos]) return k;
        return -1;
    endfunction

    localparam int BWr  = 15;
    localparam int BErr = 14;

    task automatic test_reset();
        logic [16:0] w;
        #23;
        w = {busy, reg_wr_en, frame_err, err_code, reg_wr_addr, reg_wr_data};
        checks++;
        if (w !== 17'h0) $display("FAIL reset_hold: outputs %h, required 0", w);
        else passes++;
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        w = {busy, reg_wr_en, frame_err, err_code, reg_wr_addr, reg_wr_data};
        checks++;
        if (w !== 17'h0) $display("FAIL reset_release: outputs %h, required 0", w);
        else passes++;
    endtask

    task automatic test_good_frame();
        int n, d, wc;
        sch_clear();
        put_byte(HDR, 1); put_byte(8'h03, 0); put_byte(8'h7E, 0);
        if (CsumEn) put_byte(8'h26, 0);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL good_frame: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        wc = first_bit(n, BWr);
        checks++;
        if (count_bit(n, BWr) !== 1 || count_bit(n, BErr) !== 0)
            $display("FAIL good_frame_count: writes %0d errors %0d, required 1 and 0",
                     count_bit(n, BWr), count_bit(n, BErr));
        else passes++;
        checks++;
        if (wc < 0 || obs_w[wc][11:0] !== 12'h37E)
            $display("FAIL good_frame_data: addr/data %h, required 37e", wc < 0 ? 12'h0 : obs_w[wc][11:0]);
        else passes++;
    endtask

    task automatic test_bad_addr();
        int n, d, ec;
        sch_clear();
        put_byte(HDR, 0); put_byte(8'h13, 0); put_byte(8'h7E, 0);
        put_frame(8'h05, 8'h5C, 2, 1'b1);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL bad_addr: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        ec = first_bit(n, BErr);
        checks++;
        if (ec != 2 || obs_w[ec < 0 ? 0 : ec][13:12] !== 2'b01)
            $display("FAIL bad_addr_err: first error cycle %0d, required cycle 2 with code 01", ec);
        else passes++;
        checks++;
        if (count_bit(n, BWr) !== 1)
            $display("FAIL bad_addr_next: writes %0d, required 1", count_bit(n, BWr));
        else passes++;
    endtask

    task automatic test_bad_csum();
        int n, d;
        sch_clear();
        put_byte(HDR, 1); put_byte(8'h03, 0); put_byte(8'h7E, 0); put_byte(8'h00, 0);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL bad_csum: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        checks++;
        if (count_bit(n, BErr) !== (CsumEn ? 1 : 0) || count_bit(n, BWr) !== (CsumEn ? 0 : 1))
            $display("FAIL bad_csum_count: errors %0d writes %0d, required %0d and %0d",
                     count_bit(n, BErr), count_bit(n, BWr), CsumEn ? 1 : 0, CsumEn ? 0 : 1);
        else passes++;
    endtask

    task automatic test_timeout();
        int n, d, ec;
        sch_clear();
        put_byte(HDR, 0); put_byte(8'h03, 0);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL timeout: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        ec = first_bit(n, BErr);
        checks++;
        if (ec != int'(T) + 2 || obs_w[ec < 0 ? 0 : ec][16:12] !== 5'b00111)
            $display("FAIL timeout_err: error cycle %0d, required %0d with code 11 and busy 0",
                     ec, T + 2);
        else passes++;
    endtask

    task automatic test_timeout_limit();
        int n, d;
        sch_clear();
        put_byte(HDR, 0); put_byte(8'h03, 0); put_byte(8'h7E, int'(T) - 1);
        if (CsumEn) put_byte(8'h26, 0);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL timeout_limit: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        checks++;
        if (count_bit(n, BErr) !== 0 || count_bit(n, BWr) !== 1)
            $display("FAIL timeout_limit_count: errors %0d writes %0d, required 0 and 1",
                     count_bit(n, BErr), count_bit(n, BWr));
        else passes++;
    endtask

    task automatic test_noise();
        int n, d;
        sch_clear();
        put_byte(8'h00, 1); put_byte(8'hFF, 1); put_byte(8'h5A, 0);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL noise: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
    endtask

    task automatic test_reset_midframe();
        int n, d;
        logic [16:0] w;
        sch_clear();
        put_byte(HDR, 0); put_byte(8'h03, 0);
        drive(sch_ptr + 2);
        rst_n = 1'b0;
        #2;
        w = {busy, reg_wr_en, frame_err, err_code, reg_wr_addr, reg_wr_data};
        checks++;
        if (w !== 17'h0) $display("FAIL reset_midframe: outputs %h, required 0", w);
        else passes++;
        m_addr = 4'h0; m_data = 8'h00; m_code = 2'b00;
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        sch_clear();
        put_byte(8'h7E, 1);
        put_frame(8'h0A, 8'h3C, 3, 1'b1);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL after_reset: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
    endtask

    task automatic test_no_csum();
        int n, d, wc;
        sch_clear();
        put_frame(8'h0F, 8'h11, 1, 1'b1);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL frame_0f: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
        wc = first_bit(n, BWr);
        checks++;
        if (wc < 0 || obs_w[wc][11:0] !== 12'hF11)
            $display("FAIL frame_0f_data: addr/data %h, required f11", wc < 0 ? 12'h0 : obs_w[wc][11:0]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n, d;
        sch_clear();
        put_frame(8'h03, 8'h7E, 0, 1'b1);
        put_frame(8'h05, 8'h22, 0, 1'b1);
        put_frame(8'h06, 8'h33, 1, 1'b1);
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0) $display("FAIL back_to_back: cycle %0d got %h required %h", d, obs_w[d], exp_w[d]);
        else passes++;
    endtask

    task automatic test_random(input int iter);
        int n, d, kind, gap, extra;
        sch_clear();
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            kind = int'($urandom_range(0, 5));
            gap  = int'($urandom_range(0, 3)) + extra;
            extra = 0;
            case (kind)
                0, 1: put_frame({4'h0, 4'($urandom)}, 8'($urandom), gap, 1'b1);
                2: begin
                    put_byte(HDR, gap);
                    put_byte({4'($urandom_range(1, 15)), 4'($urandom)}, 0);
                end
                3: put_frame({4'h0, 4'($urandom)}, 8'($urandom), gap, 1'b0);
                4: put_byte(8'($urandom), gap);
                default: begin
                    put_byte(HDR, gap);
                    put_byte({4'h0, 4'($urandom)}, 0);
                    extra = int'(T) + int'($urandom_range(0, 3)) - 1;
                end
            endcase
        end
        run_sched(n);
        d = first_diff(n);
        checks++;
        if (d >= 0)
            $display("FAIL random_%0d: cycle %0d got %h required %h", iter, d, obs_w[d], exp_w[d]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_addr();
        test_bad_csum();
        test_timeout();
        test_timeout_limit();
        test_noise();
        test_reset_midframe();
        test_no_csum();
        test_back_to_back();
        for (int i = 0; i < 8; i++) test_random(i);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
